// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// opcodes package: opcode enumeration shared with the ALU/opcode decode path,
// plus the items the instruction encoder needs.
//   Opcode_t   : 5-bit instruction opcode
//   enc_fmt_t  : encoding format of an opcode (R, I8, I5, or X = no encoding)
//   fmt_of()   : maps an opcode to its encoding format
//   OPW/REGW/IMM8W/IMM5W : instruction field widths
// ---------------------------------------------------------------------------
package opcodes;

    localparam int OPW   = 5;
    localparam int REGW  = 3;
    localparam int IMM8W = 8;
    localparam int IMM5W = 5;

    typedef enum logic [OPW-1:0] {
        OP_NOP  = 5'h00,
        OP_ADD  = 5'h01,
        OP_SUB  = 5'h02,
        OP_AND  = 5'h03,
        OP_OR   = 5'h04,
        OP_XOR  = 5'h05,
        OP_LUI  = 5'h08,
        OP_LLI  = 5'h09,
        OP_LDW  = 5'h0C,
        OP_STW  = 5'h0D,
        OP_ADDI = 5'h0E,
        OP_ILL  = 5'h1F
    } Opcode_t;

    typedef enum logic [1:0] {
        FmtR  = 2'd0,
        FmtI8 = 2'd1,
        FmtI5 = 2'd2,
        FmtX  = 2'd3
    } enc_fmt_t;

    // Opcodes without a defined encoding (including OP_ILL) fall into FmtX.
    function automatic enc_fmt_t fmt_of(input Opcode_t op);
        enc_fmt_t fmt;
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: fmt = FmtR;
            OP_LUI, OP_LLI:                                 fmt = FmtI8;
            OP_LDW, OP_STW, OP_ADDI:                        fmt = FmtI5;
            default:                                        fmt = FmtX;
        endcase
        return fmt;
    endfunction

endpackage : opcodes

// File: rtl/instr_encoder_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo: single-clock FIFO used as the encoder's request queue.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   push, push_data      : write side; accepted when not full or popping
//   pop, pop_data        : read side; pop_data is the current head
//   full, empty          : occupancy flags
// Parameters: DEPTH (power of two, >= 2), W (word width).
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   cnt_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign empty    = (cnt_r == '0);
    assign full     = (cnt_r == (PW+1)'(DEPTH));
    assign pop_data = mem_r[rd_ptr_r];

    // Qualify push/pop; a push while full is allowed only alongside a pop.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Storage array: data needs no reset, occupancy is tracked by cnt_r.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder: packs symbolic instruction requests into 16-bit words and
// writes them to program memory at auto-incrementing addresses, through a
// DEPTH-entry request FIFO.
// Ports:
//   Clock, nReset        : clock, synchronous active-low reset
//   Start, BaseAddr      : begin a run at BaseAddr (IDLE/DONE only)
//   Finish               : drain the queue, then enter DONE (RUN only)
//   ReqValid/ReqReady    : request handshake; OpCode, Rd, Ra, Rb, Imm fields
//   WrValid/WrReady      : memory write handshake; WrAddr, WrData
//   Busy, Done, Count, Err : status (Err is sticky until Start or reset)
// Optional feature macro INSTR_ENC_RANGE_CHECK_EN: when defined, immediate
// bits that do not fit the opcode's format are an error (word dropped, Err
// set); when undefined they are silently truncated.
// ---------------------------------------------------------------------------
module instr_encoder
    import opcodes::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Start,
    input  logic [AW-1:0]        BaseAddr,
    input  logic                 Finish,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  Opcode_t              OpCode,
    input  logic [REGW-1:0]      Rd,
    input  logic [REGW-1:0]      Ra,
    input  logic [REGW-1:0]      Rb,
    input  logic [IMM8W-1:0]     Imm,
    output logic                 WrValid,
    input  logic                 WrReady,
    output logic [AW-1:0]        WrAddr,
    output logic [15:0]          WrData,
    output logic                 Busy,
    output logic                 Done,
    output logic [AW-1:0]        Count,
    output logic                 Err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } enc_state_t;

    enc_state_t  state_r;
    enc_state_t  next_state_s;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] count_r;
    logic        err_r;

    enc_fmt_t    fmt_s;
    logic [15:0] word_s;
    logic        bad_s;
    logic        accept_s;
    logic        push_s;
    logic        start_s;
    logic        wr_valid_s;
    logic        wr_fire_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [15:0] fifo_head_s;

    // Encode the request currently on the input fields.
    always_comb begin
        fmt_s  = fmt_of(OpCode);
        word_s = 16'h0000;
        bad_s  = 1'b0;
        case (fmt_s)
            FmtR:    word_s = {OpCode, Rd, Ra, Rb, 2'b00};
            FmtI8:   word_s = {OpCode, Rd, Imm};
            FmtI5:   word_s = {OpCode, Rd, Ra, Imm[IMM5W-1:0]};
            FmtX:    bad_s  = 1'b1;
            default: bad_s  = 1'b1;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if ((fmt_s == FmtR) && (Imm != 8'h00)) begin
            bad_s = 1'b1;
        end else if ((fmt_s == FmtI5) && (Imm[7:5] != 3'b000)) begin
            bad_s = 1'b1;
        end else begin
            bad_s = bad_s;
        end
`endif
    end

    // Handshake qualifiers. Start is only honoured from IDLE or DONE, so it
    // never coincides with a memory write.
    always_comb begin
        ReqReady   = (state_r == RUN) && !fifo_full_s;
        accept_s   = ReqValid && ReqReady;
        push_s     = accept_s && !bad_s;
        start_s    = Start && ((state_r == IDLE) || (state_r == DONE));
        wr_valid_s = !fifo_empty_s && ((state_r == RUN) || (state_r == FLUSH));
        wr_fire_s  = wr_valid_s && WrReady;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (16)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (nReset),
        .push      (push_s),
        .push_data (word_s),
        .pop       (wr_fire_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next-state logic. FLUSH completes once the queue has fully drained.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) next_state_s = RUN;
                else       next_state_s = IDLE;
            end
            RUN: begin
                if (Finish) next_state_s = FLUSH;
                else        next_state_s = RUN;
            end
            FLUSH: begin
                if (fifo_empty_s) next_state_s = DONE;
                else              next_state_s = FLUSH;
            end
            DONE: begin
                if (Start) next_state_s = RUN;
                else       next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Write address and word count: loaded on Start, advanced per write.
    // The address wraps silently modulo 2^AW.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            addr_r  <= '0;
            count_r <= '0;
        end else if (start_s) begin
            addr_r  <= BaseAddr;
            count_r <= '0;
        end else if (wr_fire_s) begin
            addr_r  <= addr_r + AW'(1);
            count_r <= count_r + AW'(1);
        end else begin
            addr_r  <= addr_r;
            count_r <= count_r;
        end
    end

    // Sticky error: set by an accepted request whose word is dropped.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            err_r <= 1'b0;
        end else if (start_s) begin
            err_r <= 1'b0;
        end else if (accept_s && bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // WrData is forced to zero when idle so stale queue storage (which is not
    // reset) never appears on the bus, e.g. right after a reset.
    assign WrValid = wr_valid_s;
    assign WrData  = wr_valid_s ? fifo_head_s : 16'h0000;
    assign WrAddr  = addr_r;
    assign Count   = count_r;
    assign Err     = err_r;
    assign Busy    = (state_r != IDLE);
    assign Done    = (state_r == DONE);

endmodule : instr_encoder

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
    import opcodes::*;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        Start;
    logic [15:0] BaseAddr;
    logic        Finish;
    logic        ReqValid;
    logic        ReqReady;
    Opcode_t     OpCode;
    logic [2:0]  Rd;
    logic [2:0]  Ra;
    logic [2:0]  Rb;
    logic [7:0]  Imm;
    logic        WrValid;
    logic        WrReady;
    logic [15:0] WrAddr;
    logic [15:0] WrData;
    logic        Busy;
    logic        Done;
    logic [15:0] Count;
    logic        Err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clock = ~Clock;

    instr_encoder #(.DEPTH(4), .AW(16)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Start    (Start),
        .BaseAddr (BaseAddr),
        .Finish   (Finish),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .OpCode   (OpCode),
        .Rd       (Rd),
        .Ra       (Ra),
        .Rb       (Rb),
        .Imm      (Imm),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Busy     (Busy),
        .Done     (Done),
        .Count    (Count),
        .Err      (Err)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Offer one request for one cycle; it must be accepted.
    task automatic push_req(input string tag, input Opcode_t op, input logic [2:0] rd,
                            input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm);
        OpCode   = op;
        Rd       = rd;
        Ra       = ra;
        Rb       = rb;
        Imm      = imm;
        ReqValid = 1'b1;
        check_value({tag, "_rdy"}, ReqReady, 1);
        tick();
        ReqValid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [15:0] data, input logic [15:0] addr);
        check_value({tag, "_valid"}, WrValid, 1);
        check_value({tag, "_data"}, WrData, data);
        check_value({tag, "_addr"}, WrAddr, addr);
    endtask

    logic [15:0] exp_w [6];
    logic [15:0] exp_f [3];
    logic [15:0] exp_addr;
    logic [15:0] exp_cnt;
    int          idx;
    int          n;
    logic        rr;

    initial begin
        nReset = 1'b0; Start = 1'b0; Finish = 1'b0; BaseAddr = 16'h0000;
        ReqValid = 1'b0; WrReady = 1'b0; OpCode = OP_NOP;
        Rd = 3'd0; Ra = 3'd0; Rb = 3'd0; Imm = 8'h00;
        for (int i = 0; i < 6; i++) exp_w[i] = {OP_LLI, i[2:0], 8'h10 + i[7:0]};
        for (int i = 0; i < 3; i++) exp_f[i] = {OP_LUI, i[2:0], 8'hC0 + i[7:0]};

        // Reset state
        repeat (2) @(negedge Clock);
        check_value("rst_busy", Busy, 0);
        check_value("rst_done", Done, 0);
        check_value("rst_wrvalid", WrValid, 0);
        check_value("rst_reqready", ReqReady, 0);
        check_value("rst_count", Count, 0);
        check_value("rst_err", Err, 0);
        check_value("rst_wraddr", WrAddr, 0);
        check_value("rst_wrdata", WrData, 0);
        nReset = 1'b1;
        tick();

        // Basic write
        BaseAddr = 16'h0100; Start = 1'b1; WrReady = 1'b1;
        tick();
        Start = 1'b0;
        check_value("start_busy", Busy, 1);
        check_value("start_rdy", ReqReady, 1);
        check_value("start_addr", WrAddr, 16'h0100);
        push_req("add", OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
        expect_write("add_wr", 16'h094C, 16'h0100);
        tick();
        check_value("add_count", Count, 1);
        check_value("add_idle", WrValid, 0);

        // I8 format, back to back
        push_req("lui", OP_LUI, 3'd5, 3'd0, 3'd0, 8'hA5);
        expect_write("lui_wr", 16'h45A5, 16'h0101);
        push_req("lli", OP_LLI, 3'd2, 3'd0, 3'd0, 8'h3C);
        expect_write("lli_wr", 16'h4A3C, 16'h0102);
        check_value("lli_count_mid", Count, 2);
        tick();
        check_value("lli_count", Count, 3);

        // Back-pressure: 6 requests offered for 10 cycles with WrReady low
        WrReady = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                ReqValid = 1'b1; OpCode = OP_LLI; Rd = idx[2:0]; Imm = 8'h10 + idx[7:0];
            end else begin
                ReqValid = 1'b0;
            end
            rr = ReqReady;
            if (c > 0) begin
                check_value("bp_data", WrData, exp_w[0]);
                check_value("bp_addr", WrAddr, 16'h0103);
            end
            tick();
            if (rr && (idx < 6)) idx++;
        end
        ReqValid = 1'b0;
        check_value("bp_accepts", idx, 4);
        check_value("bp_ready_low", ReqReady, 0);
        WrReady = 1'b1;
        n = 0;
        for (int c = 0; c < 8 && n < 4; c++) begin
            if (WrValid) begin
                check_value("bp_drain_data", WrData, exp_w[n]);
                check_value("bp_drain_addr", WrAddr, 16'h0103 + 16'(n));
                n++;
            end
            tick();
        end
        check_value("bp_drain_n", n, 4);
        check_value("bp_count", Count, 7);

        // Flush with 3 words queued
        WrReady = 1'b0;
        for (int i = 0; i < 3; i++) push_req("fl_q", OP_LUI, i[2:0], 3'd0, 3'd0, 8'hC0 + 8'(i));
        Finish = 1'b1;
        tick();
        Finish = 1'b0;
        check_value("fl_busy0", Busy, 1);
        check_value("fl_done0", Done, 0);
        ReqValid = 1'b1; OpCode = OP_LLI; Rd = 3'd7; Imm = 8'h77;
        WrReady = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && !Done; c++) begin
            check_value("fl_busy", Busy, 1);
            check_value("fl_rdy_low", ReqReady, 0);
            if (WrValid) begin
                if (n < 3) check_value("fl_data", WrData, exp_f[n]);
                n++;
            end
            tick();
        end
        ReqValid = 1'b0;
        check_value("fl_done", Done, 1);
        check_value("fl_writes", n, 3);
        check_value("fl_count", Count, 10);
        check_value("fl_wrvalid", WrValid, 0);

        // Address wrap and errors
        BaseAddr = 16'hFFFF; Start = 1'b1;
        tick();
        Start = 1'b0;
        check_value("wr_done_clr", Done, 0);
        check_value("wr_count0", Count, 0);
        check_value("wr_base", WrAddr, 16'hFFFF);
        push_req("ldw", OP_LDW, 3'd3, 3'd4, 3'd0, 8'h15);
        expect_write("ldw_wr", 16'h6395, 16'hFFFF);
        tick();
        push_req("wrap", OP_LLI, 3'd2, 3'd0, 3'd0, 8'h3C);
        expect_write("wrap_wr", 16'h4A3C, 16'h0000);
        tick();
        check_value("wrap_count", Count, 2);
        check_value("pre_err", Err, 0);
        push_req("fmtx", OP_ILL, 3'd1, 3'd1, 3'd1, 8'h00);
        check_value("fmtx_err", Err, 1);
        check_value("fmtx_nowr", WrValid, 0);
        check_value("fmtx_count", Count, 2);
        push_req("range", OP_LDW, 3'd1, 3'd2, 3'd0, 8'h20);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        check_value("range_drop", WrValid, 0);
        exp_cnt  = 16'd2;
        exp_addr = 16'h0001;
`else
        expect_write("range_wr", 16'h6140, 16'h0001);
        exp_cnt  = 16'd3;
        exp_addr = 16'h0002;
`endif
        tick();
        check_value("range_count", Count, exp_cnt);
        check_value("range_err", Err, 1);

        // Start while running is ignored
        BaseAddr = 16'h1234; Start = 1'b1;
        tick();
        Start = 1'b0;
        check_value("ign_addr", WrAddr, exp_addr);
        check_value("ign_err", Err, 1);
        check_value("ign_count", Count, exp_cnt);

        // Reset mid-write
        WrReady = 1'b0;
        push_req("mid", OP_LUI, 3'd5, 3'd0, 3'd0, 8'hA5);
        check_value("mid_pending", WrValid, 1);
        nReset = 1'b0;
        tick();
        check_value("mr_wrvalid", WrValid, 0);
        check_value("mr_wrdata", WrData, 0);
        check_value("mr_wraddr", WrAddr, 0);
        check_value("mr_busy", Busy, 0);
        check_value("mr_done", Done, 0);
        check_value("mr_count", Count, 0);
        check_value("mr_err", Err, 0);
        check_value("mr_rdy", ReqReady, 0);
        nReset = 1'b1;

        // Start and Finish together from IDLE: Start wins
        BaseAddr = 16'h0200; Start = 1'b1; Finish = 1'b1;
        tick();
        Start = 1'b0; Finish = 1'b0;
        check_value("sf_rdy", ReqReady, 1);
        check_value("sf_fifo_empty", WrValid, 0);
        check_value("sf_addr", WrAddr, 16'h0200);
        tick();
        check_value("sf_not_done", Done, 0);
        check_value("sf_still_run", ReqReady, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_instr_encoder
